// File: rtl/relu_pkg.sv
// Shared fp32 types and helpers for the multi-lane ReLU backward block.
package relu_pkg;

    localparam int         FP32_W       = 32;
    localparam logic [7:0] FP32_EXP_MAX = 8'd255;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    // Strictly positive: sign clear and not +0. Positive Inf/NaN count as positive.
    function automatic logic fp32_is_positive(input fp32_t v);
        return !v.sign && ({v.exp, v.mant} != 31'd0);
    endfunction

endpackage

// File: rtl/relu_backward_lane.sv
// One lane of the ReLU backward datapath, purely combinational.
// Two independent paths: classify the forward activation (feeds stage 1)
// and scale the registered gradient by 2^-NEG_SLOPE_SHIFT (feeds stage 2).
module relu_backward_lane
    import relu_pkg::*;
#(
    parameter int NEG_SLOPE_SHIFT = 13
) (
    input  logic [FP32_W-1:0] act_i,
    output logic              act_pos_o,
    input  logic              pos_i,
    input  logic [FP32_W-1:0] diff_i,
    output logic [FP32_W-1:0] diff_o
);

    localparam logic [7:0] SHIFT = NEG_SLOPE_SHIFT[7:0];

    fp32_t diff_f;

    assign diff_f    = diff_i;
    assign act_pos_o = fp32_is_positive(act_i);

    // Power-of-two scaling is an exponent subtract; anything that would
    // underflow into the denormal range is flushed to a signed zero.
    always_comb begin
        diff_o = diff_i;
        if (!pos_i) begin
            if (diff_f.exp == FP32_EXP_MAX) begin
                diff_o = diff_i;
            end else if (diff_f.exp <= SHIFT) begin
                diff_o = {diff_f.sign, 31'd0};
            end else begin
                diff_o = {diff_f.sign, diff_f.exp - SHIFT, diff_f.mant};
            end
        end
    end

endmodule

// File: rtl/relu_backward_lanes.sv
// Multi-lane streaming ReLU backward: two-stage pipeline behind valid/ready.
// Optional non-positive lane counter enabled by RELU_BWD_STATS_EN.
module relu_backward_lanes
    import relu_pkg::*;
#(
    parameter int LANES           = 4,
    parameter int NEG_SLOPE_SHIFT = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FP32_W*LANES-1:0]   in_data,
    input  logic [FP32_W*LANES-1:0]   in_diff,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FP32_W*LANES-1:0]   out_diff,
    input  logic                      clear_count,
    output logic [31:0]               neg_count
);

    logic                      adv;
    logic [LANES-1:0]          in_pos;
    logic [FP32_W*LANES-1:0]   lane_res;

    logic                      s1_valid_q,  s1_valid_d;
    logic [LANES-1:0]          s1_pos_q,    s1_pos_d;
    logic [FP32_W*LANES-1:0]   s1_diff_q,   s1_diff_d;
    logic                      out_valid_q, out_valid_d;
    logic [FP32_W*LANES-1:0]   out_diff_q,  out_diff_d;

    // Whole pipeline advances together; output register is free or being drained.
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_diff  = out_diff_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        relu_backward_lane #(
            .NEG_SLOPE_SHIFT (NEG_SLOPE_SHIFT)
        ) u_lane (
            .act_i     (in_data[FP32_W*i +: FP32_W]),
            .act_pos_o (in_pos[i]),
            .pos_i     (s1_pos_q[i]),
            .diff_i    (s1_diff_q[FP32_W*i +: FP32_W]),
            .diff_o    (lane_res[FP32_W*i +: FP32_W])
        );
    end

    // Next-state for both pipeline stages; everything holds while stalled.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_pos_d    = s1_pos_q;
        s1_diff_d   = s1_diff_q;
        out_valid_d = out_valid_q;
        out_diff_d  = out_diff_q;
        if (adv) begin
            s1_valid_d  = in_valid;
            s1_pos_d    = in_pos;
            s1_diff_d   = in_diff;
            out_valid_d = s1_valid_q;
            out_diff_d  = lane_res;
        end
    end

    // Pipeline registers with synchronous reset discarding in-flight beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_pos_q    <= '0;
            s1_diff_q   <= '0;
            out_valid_q <= 1'b0;
            out_diff_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_pos_q    <= s1_pos_d;
            s1_diff_q   <= s1_diff_d;
            out_valid_q <= out_valid_d;
            out_diff_q  <= out_diff_d;
        end
    end

`ifdef RELU_BWD_STATS_EN
    logic        accept;
    logic [5:0]  beat_neg;
    logic [31:0] count_base;
    logic [32:0] count_sum;
    logic [31:0] neg_count_q, neg_count_d;

    assign accept    = in_valid && adv;
    assign neg_count = neg_count_q;

    // Clear and accept in the same cycle restarts the count from this beat.
    always_comb begin
        beat_neg = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_neg = beat_neg + {5'd0, !in_pos[i]};
        end
        count_base  = clear_count ? 32'd0 : neg_count_q;
        count_sum   = {1'b0, count_base} + (accept ? {27'd0, beat_neg} : 33'd0);
        neg_count_d = count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
    end

    // Saturating non-positive lane counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_count_q <= '0;
        end else begin
            neg_count_q <= neg_count_d;
        end
    end
`else
    logic unused_clear_count;

    assign unused_clear_count = clear_count;
    assign neg_count          = 32'd0;
`endif

endmodule

// File: tb/tb_relu_backward_lanes.sv
// Self-checking bench for relu_backward_lanes: directed vectors, backpressure,
// counter, mid-stream reset and a randomized run against a behavioural model.
module tb_relu_backward_lanes;

    localparam int LANES  = 4;
    localparam int SHIFT  = 13;
    localparam int W      = 32 * LANES;
    localparam int NBEATS = 10000;
`ifdef RELU_BWD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] in_diff = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_diff;
    logic         clear_count = 1'b0;
    logic [31:0]  neg_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    relu_backward_lanes #(
        .LANES           (LANES),
        .NEG_SLOPE_SHIFT (SHIFT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_diff     (in_diff),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_diff    (out_diff),
        .clear_count (clear_count),
        .neg_count   (neg_count)
    );

    // Reference: gradient passes where activation > 0, else multiply by 2^-SHIFT
    // (exact exponent decrement), flushing results that leave the normal range.
    function automatic logic [31:0] ref_lane(input logic [31:0] a, input logic [31:0] g);
        int unsigned e;
        e = int'(g[30:23]);
        if (a[31] == 1'b0 && a[30:0] != 31'd0) return g;
        if (e == 255) return g;
        if (e <= SHIFT) return {g[31], 31'd0};
        return g - (32'(SHIFT) << 23);
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic [W-1:0] a, input logic [W-1:0] g);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[32*i +: 32] = ref_lane(a[32*i +: 32], g[32*i +: 32]);
        return r;
    endfunction

    function automatic int ref_negs(input logic [W-1:0] a);
        int n = 0;
        for (int i = 0; i < LANES; i++) begin
            if (a[32*i + 31] == 1'b1 || a[32*i +: 31] == 31'd0) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'($urandom_range(0, SHIFT + 1));
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] b;
        for (int i = 0; i < LANES; i++) b[32*i +: 32] = rand_fp();
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_count = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b want=0", out_valid); else n_pass++;
        n_total++;
        if (out_diff !== '0) $display("FAIL reset_out_diff got=%h want=0", out_diff); else n_pass++;
        n_total++;
        if (neg_count !== 32'd0) $display("FAIL reset_neg_count got=%h want=0", neg_count); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b want=1", in_ready); else n_pass++;
    endtask

    // Lane 0 carries the vector; other lanes random, checked through the model.
    task automatic test_directed();
        logic [31:0]  vec [7][3] = '{
            '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000},
            '{32'hBF80_0000, 32'h4000_0000, 32'h3980_0000},
            '{32'hBF80_0000, 32'hC000_0000, 32'hB980_0000},
            '{32'h0000_0000, 32'h3F80_0000, 32'h3900_0000},
            '{32'h8000_0000, 32'h3F80_0000, 32'h3900_0000},
            '{32'hBF80_0000, 32'h8500_0000, 32'h8000_0000},
            '{32'hBF80_0000, 32'h7FC0_0000, 32'h7FC0_0000}};
        logic [W-1:0] a, g, want;
        do_reset();
        for (int v = 0; v < 7; v++) begin
            a = rand_beat(); g = rand_beat();
            a[31:0] = vec[v][0]; g[31:0] = vec[v][1];
            want = ref_beat(a, g);
            @(negedge clk);
            in_valid = 1'b1; in_data = a; in_diff = g; out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL dir%0d_early_valid got=%0b want=0", v, out_valid); else n_pass++;
            @(posedge clk);
            #1;
            n_total++;
            if (out_valid !== 1'b1) $display("FAIL dir%0d_latency got=%0b want=1", v, out_valid); else n_pass++;
            n_total++;
            if (out_diff[31:0] !== vec[v][2]) $display("FAIL dir%0d_lane0 got=%h want=%h", v, out_diff[31:0], vec[v][2]); else n_pass++;
            n_total++;
            if (out_diff !== want) $display("FAIL dir%0d_beat got=%h want=%h", v, out_diff, want); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a [8];
        logic [W-1:0] g [8];
        logic [W-1:0] q [$];
        logic [W-1:0] held = '0;
        logic [W-1:0] want;
        bit prev_stall = 1'b0;
        int sent = 0, recv = 0, cyc = 0, stalls = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin a[i] = rand_beat(); g[i] = rand_beat(); end
        while (recv < 8 && cyc < 100) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 9);
            in_valid  = (sent < 8);
            if (sent < 8) begin in_data = a[sent]; in_diff = g[sent]; end
            cyc++;
            #1;
            if (prev_stall) begin
                n_total++;
                if (out_valid !== 1'b1 || out_diff !== held)
                    $display("FAIL bp_hold got=%0b/%h want=1/%h", out_valid, out_diff, held);
                else n_pass++;
            end
            if (out_valid && !out_ready) begin
                stalls++;
                n_total++;
                if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%0b want=0", in_ready); else n_pass++;
            end
            if (out_valid && out_ready) begin
                want = (q.size() > 0) ? q.pop_front() : '0;
                n_total++;
                if (out_diff !== want) $display("FAIL bp_beat%0d got=%h want=%h", recv, out_diff, want); else n_pass++;
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_beat(a[sent], g[sent]));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            held = out_diff;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_total++;
        if (recv !== 8) $display("FAIL bp_count got=%0d want=8", recv); else n_pass++;
        n_total++;
        if (stalls < 5) $display("FAIL bp_stall_cycles got=%0d want>=5", stalls); else n_pass++;
    endtask

    task automatic send_beat(input logic [W-1:0] a, input logic clr);
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; in_data = a; in_diff = rand_beat(); clear_count = clr;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; clear_count = 1'b0;
    endtask

    task automatic test_counter();
        logic [W-1:0] two_neg  = {32'h3F80_0000, 32'h8000_0000, 32'hC120_0000, 32'h0000_0001};
        logic [W-1:0] four_neg = {32'hBF80_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFC0_0000};
        do_reset();
        for (int i = 0; i < 3; i++) send_beat(two_neg, 1'b0);
        #1;
        n_total++;
        if (neg_count !== (STATS ? 32'd6 : 32'd0)) $display("FAIL cnt_accum got=%0d want=%0d", neg_count, STATS ? 6 : 0); else n_pass++;
        send_beat(four_neg, 1'b1);
        #1;
        n_total++;
        if (neg_count !== (STATS ? 32'd4 : 32'd0)) $display("FAIL cnt_clear_accept got=%0d want=%0d", neg_count, STATS ? 4 : 0); else n_pass++;
        clear_count = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_count = 1'b0;
        #1;
        n_total++;
        if (neg_count !== 32'd0) $display("FAIL cnt_clear got=%0d want=0", neg_count); else n_pass++;
`ifdef RELU_BWD_STATS_EN
        @(negedge clk);
        force dut.neg_count_q = 32'hFFFF_FFFD;
        #1;
        release dut.neg_count_q;
        send_beat(four_neg, 1'b0);
        #1;
        n_total++;
        if (neg_count !== 32'hFFFF_FFFF) $display("FAIL cnt_saturate got=%h want=ffffffff", neg_count); else n_pass++;
        send_beat(four_neg, 1'b0);
        #1;
        n_total++;
        if (neg_count !== 32'hFFFF_FFFF) $display("FAIL cnt_sat_hold got=%h want=ffffffff", neg_count); else n_pass++;
`endif
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; in_data = {4{32'h8000_0000}}; in_diff = rand_beat();
        @(posedge clk);
        @(negedge clk);
        in_data = rand_beat(); in_diff = rand_beat();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got=%0b want=0", out_valid); else n_pass++;
        n_total++;
        if (neg_count !== 32'd0) $display("FAIL rst_mid_count got=%0d want=0", neg_count); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        n_total++;
        if (stale != 0) $display("FAIL rst_mid_stale got=%0d want=0", stale); else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] q [$];
        logic [W-1:0] held = '0;
        logic [W-1:0] want;
        longint nc = 0;
        bit prev_stall = 1'b0;
        int sent = 0, recv = 0, cyc = 0;
        do_reset();
        while (recv < NBEATS && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid    = (sent < NBEATS) && ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            clear_count = ($urandom_range(0, 99) == 0);
            in_data     = rand_beat();
            in_diff     = rand_beat();
            #1;
            n_total++;
            if (neg_count !== (STATS ? 32'(nc) : 32'd0)) $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, neg_count, STATS ? nc : 0); else n_pass++;
            if (prev_stall) begin
                n_total++;
                if (out_valid !== 1'b1 || out_diff !== held)
                    $display("FAIL rnd_hold cyc=%0d got=%0b/%h want=1/%h", cyc, out_valid, out_diff, held);
                else n_pass++;
            end
            if (out_valid && !out_ready) begin
                n_total++;
                if (in_ready !== 1'b0) $display("FAIL rnd_in_ready cyc=%0d got=%0b want=0", cyc, in_ready); else n_pass++;
            end
            if (out_valid && out_ready) begin
                want = (q.size() > 0) ? q.pop_front() : '0;
                n_total++;
                if (out_diff !== want) $display("FAIL rnd_beat%0d got=%h want=%h", recv, out_diff, want); else n_pass++;
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_beat(in_data, in_diff));
                nc = (clear_count ? 0 : nc) + ref_negs(in_data);
                if (nc > 64'hFFFF_FFFF) nc = 64'hFFFF_FFFF;
                sent++;
            end else if (clear_count) begin
                nc = 0;
            end
            prev_stall = out_valid && !out_ready;
            held = out_diff;
        end
        in_valid = 1'b0; out_ready = 1'b1; clear_count = 1'b0;
        n_total++;
        if (recv !== NBEATS) $display("FAIL rnd_delivered got=%0d want=%0d", recv, NBEATS); else n_pass++;
        n_total++;
        if (q.size() != 0) $display("FAIL rnd_leftover got=%0d want=0", q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_counter();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
